// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: header/payload framing, channel routing and MISO status/data for the SPI byte slave
module spi_frame_sequencer #(
  parameter int NUM_CH = 4,
  parameter logic [2:0] STATUS_ID = 3'b101
) (
  input  logic                  w_SPI_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  input  logic [NUM_CH-1:0]     i_Ch_Ready,
  input  logic [8*NUM_CH-1:0]   i_Ch_TX_Data,
  output logic [1:0]            o_Ch_Sel,
  output logic [7:0]            o_Wr_Byte,
  output logic [NUM_CH-1:0]     o_Ch_Wr_Strobe,
  output logic [NUM_CH-1:0]     o_Ch_Rd_Strobe,
  output logic                  o_MISO_Bit,
  output logic                  o_Busy,
  output logic                  o_Frame_Err
);
  typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [4:0] rem_q, rem_d;
  logic [1:0] sel_q, sel_d;
  logic rw_q, rw_d;
  logic [7:0] tx_q, tx_d;
  logic [NUM_CH-1:0] wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
  logic err_q, err_d;
  logic [7:0] wr_byte_q, wr_byte_d;
  logic frame_rst_n, byte_done, h_bad;
  logic [7:0] rx_byte, status;
  logic [3:0] rdy4;
  logic [31:0] tx_all;
  function automatic logic [NUM_CH-1:0] onehot(input logic [1:0] c);
    return NUM_CH'(4'b0001 << c);
  endfunction
  assign frame_rst_n = i_Rst_L & ~i_SPI_CS_n;
  assign rdy4 = 4'(i_Ch_Ready);
  assign tx_all = 32'(i_Ch_TX_Data);
  assign rx_byte = {rx_q, i_SPI_MOSI};
  assign byte_done = bit_cnt_q == 3'd7;
  assign h_bad = rx_byte[4] | ({30'b0, rx_byte[6:5]} >= 32'(NUM_CH)) | ~rdy4[rx_byte[6:5]];
  assign status = {err_q, STATUS_ID, rdy4};
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    rx_d = rx_byte[6:0];
    rem_d = rem_q;
    sel_d = sel_q;
    rw_d = rw_q;
    tx_d = tx_q;
    wr_stb_d = '0;
    rd_stb_d = '0;
    err_d = err_q;
    wr_byte_d = wr_byte_q;
    if (byte_done && state_q == HDR) begin
      err_d = h_bad;
      state_d = h_bad ? ERR : DATA;
      if (!h_bad) begin
        sel_d = rx_byte[6:5];
        rw_d = rx_byte[7];
        rem_d = {1'b0, rx_byte[3:0]} + 5'd1;
        if (rx_byte[7]) begin
          tx_d = tx_all[8*rx_byte[6:5] +: 8];
          rd_stb_d = onehot(rx_byte[6:5]);
        end
      end
    end else if (byte_done && state_q == DATA) begin
      rem_d = rem_q - 5'd1;
      state_d = rem_d == 5'd0 ? DONE : DATA;
      if (!rw_q) begin
        wr_byte_d = rx_byte;
        wr_stb_d = onehot(sel_q);
      end else if (rem_d != 5'd0) begin
        tx_d = tx_all[8*sel_q +: 8];
        rd_stb_d = onehot(sel_q);
      end
    end
  end
  // frame state is also cleared asynchronously whenever CS_n is high
  always_ff @(posedge w_SPI_Clk or negedge frame_rst_n)
    if (!frame_rst_n) begin
      state_q <= HDR;
      bit_cnt_q <= '0;
      rx_q <= '0;
      rem_q <= '0;
      sel_q <= '0;
      rw_q <= 1'b0;
      tx_q <= '0;
      wr_stb_q <= '0;
      rd_stb_q <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q <= rx_d;
      rem_q <= rem_d;
      sel_q <= sel_d;
      rw_q <= rw_d;
      tx_q <= tx_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
    end
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      err_q <= 1'b0;
      wr_byte_q <= '0;
    end else if (!i_SPI_CS_n) begin
      err_q <= err_d;
      wr_byte_q <= wr_byte_d;
    end
  assign o_MISO_Bit = state_q == HDR ? status[~bit_cnt_q] :
                      (state_q == DATA && rw_q) ? tx_q[~bit_cnt_q] : 1'b1;
  assign o_Ch_Sel = sel_q;
  assign o_Wr_Byte = wr_byte_q;
  assign o_Ch_Wr_Strobe = wr_stb_q;
  assign o_Ch_Rd_Strobe = rd_stb_q;
  assign o_Busy = state_q == DATA;
  assign o_Frame_Err = err_q;
endmodule
